alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-side initiator for the fixed-point ALU's valid/busy/out_valid handshake. It accepts instruction packets from an upstream source into a small FIFO and issues them to the ALU one at a time. It waits for each result, then returns it with its instruction tag through a ready/valid result port. It sits between the test/control sequencer and the ALU, and is the only block that drives the ALU's input pins.

## Interface
Parameters:
- INST_W, 4, instruction width
- DATA_W, 16, data width (Q6.10 signed)
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 15, maximum cycles spent in WAIT before the result is forced

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  FIFO can accept
- i_cmd_inst  in  INST_W  instruction
- i_cmd_a  in  DATA_W  operand A
- i_cmd_b  in  DATA_W  operand B
- o_alu_valid  out  1  one-cycle issue strobe to ALU
- i_alu_busy  in  1  ALU busy
- o_alu_inst  out  INST_W  issued instruction
- o_alu_data_a  out  DATA_W  issued operand A
- o_alu_data_b  out  DATA_W  issued operand B
- i_alu_out_valid  in  1  ALU result strobe
- i_alu_data  in  DATA_W  ALU result
- o_res_valid  out  1  result available
- i_res_ready  in  1  consumer takes result
- o_res_data  out  DATA_W  captured result
- o_res_inst  out  INST_W  instruction tag of the result
- o_res_timeout  out  1  result was forced by timeout
- o_issue_cnt  out  8  number of issued commands, wraps at 255→0

## Operation
- FIFO: push on i_cmd_valid && o_cmd_ready. o_cmd_ready = !full, computed from registered count only. When full, o_cmd_ready stays low even in a pop cycle. Push and pop in the same cycle are both performed, and the count is unchanged.
- The FSM has four states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: when the FIFO is non-empty and i_alu_busy=0, go to ISSUE. Otherwise stay.
  - ISSUE: o_alu_valid=1 for exactly this cycle. o_alu_inst/a/b carry the FIFO head. Pop the head, latch its inst as the tag, increment o_issue_cnt, clear the wait counter, then go to WAIT.
  - WAIT: o_alu_valid=0. On i_alu_out_valid, capture i_alu_data into o_res_data, set o_res_timeout=0, and go to HOLD. The counter increments each WAIT cycle. When it reaches TIMEOUT without out_valid: o_res_data=0, o_res_timeout=1, go to HOLD. If out_valid and timeout coincide, out_valid wins.
  - HOLD: o_res_valid=1. o_res_data, o_res_inst and o_res_timeout stay stable. When i_res_ready=1, go to IDLE.
- A stray i_alu_out_valid outside WAIT is ignored.
- o_alu_inst/a/b hold their last issued values outside ISSUE. Their reset value is 0.
- Reset value of every output is 0, except o_cmd_ready, which is 1 from the first cycle after reset. Reset empties the FIFO, zeroes pointers and counters, and returns the FSM to IDLE.
- Reset asserted mid-WAIT or mid-HOLD abandons the in-flight result without reporting it.

## Timing
- Command accepted in cycle t → FIFO count=1 in t+1 (IDLE) → ISSUE in t+2 (o_alu_valid=1).
- With the ALU's 2-cycle response (busy in t+3..t+4, out_valid in t+4): HOLD in t+5, o_res_valid=1.
- Accept-to-result latency is 5 cycles. Minimum issue interval is 4 cycles (ISSUE, WAIT, WAIT, HOLD with ready=1), plus 1 cycle in IDLE.
- o_alu_valid is never asserted while i_alu_busy=1 was sampled in the preceding IDLE cycle. It is never asserted on two consecutive cycles.
- All outputs are registered or decoded only from registered state/count; there are no input-to-output combinational paths.

## Configuration
- ALU_ISSUE_TIMEOUT_EN defined: the WAIT counter and TIMEOUT exit are present as described.
- ALU_ISSUE_TIMEOUT_EN undefined: there is no counter, WAIT exits only on i_alu_out_valid, and o_res_timeout is tied to 0. TIMEOUT is ignored.

## Test plan
- Single ADD, cmd (0, 0x0400, 0x0800) at cycle t, with the ALU model returning 0x0C00 → o_alu_valid in t+2 only; o_res_valid in t+5 with data 0x0C00, inst 0, timeout 0; o_issue_cnt=1.
- Four back-to-back pushes with the ALU held busy → o_cmd_ready=0 after the 4th; a 5th offer is not accepted. On releasing busy, results return in push order with tags 0,1,2,3.
- i_res_ready=0 for 10 cycles in HOLD → o_res_valid, data and tag are stable. No second o_alu_valid occurs despite a non-empty FIFO.
- i_alu_out_valid never asserted, TIMEOUT=15 → HOLD entered after 15 WAIT cycles with o_res_timeout=1 and data 0x0000. With the macro undefined, the issuer stays in WAIT indefinitely.
- i_rst pulsed for one cycle during WAIT with 2 entries queued → the next cycle shows all outputs 0, o_cmd_ready=1 and an empty FIFO. A late i_alu_out_valid is ignored.
- 256 issued commands → o_issue_cnt wraps to 0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands in a small FIFO, issues them one at a
// time over the ALU valid/busy/out_valid handshake, and returns each result
// with its instruction tag on a ready/valid result port.
// Optional feature macro: ALU_ISSUE_TIMEOUT_EN adds a WAIT-state cycle counter
// that forces a zero result flagged by o_res_timeout after TIMEOUT cycles.
// With the macro undefined, WAIT exits only on i_alu_out_valid.
module alu_cmd_issuer #(
  parameter int INST_W     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [INST_W-1:0] i_cmd_inst,
  input  logic [DATA_W-1:0] i_cmd_a,
  input  logic [DATA_W-1:0] i_cmd_b,
  output logic              o_alu_valid,
  input  logic              i_alu_busy,
  output logic [INST_W-1:0] o_alu_inst,
  output logic [DATA_W-1:0] o_alu_data_a,
  output logic [DATA_W-1:0] o_alu_data_b,
  input  logic              i_alu_out_valid,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic [INST_W-1:0] o_res_inst,
  output logic              o_res_timeout,
  output logic [7:0]        o_issue_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = INST_W + 2 * DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Issue / result state
  state_e            state_q, state_d;
  logic [INST_W-1:0] alu_inst_q, alu_inst_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [INST_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [INST_W-1:0] res_inst_q, res_inst_d;
  logic [7:0]        issue_cnt_q, issue_cnt_d;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TIMEOUT_C = TMO_W'(TIMEOUT);
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TMO_W-1:0] wait_inc_s;
  logic             res_timeout_q, res_timeout_d;
`else
  // TIMEOUT has no effect in this build
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT != 0);
`endif

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [ENT_W-1:0] head_s;

  // Ready and FIFO status come only from the registered count, so a pop in
  // the same cycle never opens the input while full.
  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign push_s  = i_cmd_valid && !full_s;
  assign pop_s   = (state_q == ISSUE);
  assign head_s  = mem_q[rd_ptr_q];

  // FIFO next-state: write at tail, advance head on issue, track occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {i_cmd_inst, i_cmd_a, i_cmd_b};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  assign wait_inc_s = wait_cnt_q + TMO_W'(1);
`endif

  // Issue FSM next-state: operands are loaded on the IDLE->ISSUE edge so they
  // appear together with the one-cycle o_alu_valid strobe and hold afterwards.
  always_comb begin
    state_d     = state_q;
    alu_inst_d  = alu_inst_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    tag_d       = tag_q;
    res_data_d  = res_data_q;
    res_inst_d  = res_inst_q;
    issue_cnt_d = issue_cnt_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_s && !i_alu_busy) begin
          state_d                       = ISSUE;
          {alu_inst_d, alu_a_d, alu_b_d} = head_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        tag_d       = head_s[ENT_W-1 -: INST_W];
        issue_cnt_d = issue_cnt_q + 8'd1;
`ifdef ALU_ISSUE_TIMEOUT_EN
        wait_cnt_d  = {TMO_W{1'b0}};
`endif
        state_d     = WAIT;
      end
      WAIT: begin
        // A real result always beats a coincident timeout
        if (i_alu_out_valid) begin
          res_data_d    = i_alu_data;
          res_inst_d    = tag_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          state_d       = HOLD;
        end else begin
`ifdef ALU_ISSUE_TIMEOUT_EN
          if (wait_inc_s == TIMEOUT_C) begin
            res_data_d    = {DATA_W{1'b0}};
            res_inst_d    = tag_q;
            res_timeout_d = 1'b1;
            state_d       = HOLD;
          end else begin
            wait_cnt_d = wait_inc_s;
          end
`else
          state_d = WAIT;
`endif
        end
      end
      HOLD: begin
        if (i_res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      state_q     <= IDLE;
      alu_inst_q  <= {INST_W{1'b0}};
      alu_a_q     <= {DATA_W{1'b0}};
      alu_b_q     <= {DATA_W{1'b0}};
      tag_q       <= {INST_W{1'b0}};
      res_data_q  <= {DATA_W{1'b0}};
      res_inst_q  <= {INST_W{1'b0}};
      issue_cnt_q <= 8'd0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_cnt_q    <= {TMO_W{1'b0}};
      res_timeout_q <= 1'b0;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      alu_inst_q  <= alu_inst_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      tag_q       <= tag_d;
      res_data_q  <= res_data_d;
      res_inst_q  <= res_inst_d;
      issue_cnt_q <= issue_cnt_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  assign o_cmd_ready  = !full_s;
  assign o_alu_valid  = (state_q == ISSUE);
  assign o_alu_inst   = alu_inst_q;
  assign o_alu_data_a = alu_a_q;
  assign o_alu_data_b = alu_b_q;
  assign o_res_valid  = (state_q == HOLD);
  assign o_res_data   = res_data_q;
  assign o_res_inst   = res_inst_q;
  assign o_issue_cnt  = issue_cnt_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
  assign o_res_timeout = res_timeout_q;
`else
  assign o_res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus a randomized
// run scored against a queue-based model of the command stream and an ALU
// responder with a 2-cycle busy window.
module tb_alu_cmd_issuer;
  localparam int INST_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int TMO    = 15;
  localparam int ENT_W  = INST_W + 2 * DATA_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_inst = 4'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        alu_valid;
  logic        alu_busy_w;
  logic [3:0]  alu_inst;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_ov_w;
  logic [15:0] alu_data_w;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [3:0]  res_inst;
  logic        res_timeout;
  logic [7:0]  issue_cnt;

  // ALU responder state
  int          m_ph = 0;
  logic        m_busy = 1'b0;
  logic        m_ov = 1'b0;
  logic [15:0] m_data = 16'd0;
  logic        force_busy = 1'b0;
  logic        inj_ov = 1'b0;
  logic        alu_respond = 1'b1;

  int checks = 0;
  int errors = 0;
  int exp_issue = 0;
  logic [ENT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign alu_busy_w = m_busy | force_busy;
  assign alu_ov_w   = m_ov | inj_ov;
  assign alu_data_w = inj_ov ? 16'hBEEF : m_data;

  alu_cmd_issuer #(
    .INST_W(INST_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_inst(cmd_inst), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
    .o_alu_valid(alu_valid), .i_alu_busy(alu_busy_w),
    .o_alu_inst(alu_inst), .o_alu_data_a(alu_a), .o_alu_data_b(alu_b),
    .i_alu_out_valid(alu_ov_w), .i_alu_data(alu_data_w),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_inst(res_inst),
    .o_res_timeout(res_timeout), .o_issue_cnt(issue_cnt)
  );

  // Arithmetic the ALU stand-in performs on each instruction
  function automatic logic [15:0] alu_ref(input logic [3:0] i, input logic [15:0] a, input logic [15:0] b);
    case (i)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU stand-in: busy for the two cycles after a strobe, result in the second
  always @(posedge clk) begin
    m_ov <= 1'b0;
    if (m_ph == 0) begin
      m_busy <= 1'b0;
      if (alu_valid === 1'b1) begin
        m_ph   <= 2;
        m_busy <= 1'b1;
        m_data <= alu_ref(alu_inst, alu_a, alu_b);
      end
    end else if (m_ph == 2) begin
      m_ph   <= 1;
      m_busy <= 1'b1;
      m_ov   <= alu_respond;
    end else begin
      m_ph   <= 0;
      m_busy <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; force_busy = 1'b0; inj_ov = 1'b0;
    exp_q.delete();
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({alu_valid, res_valid, res_timeout, issue_cnt, res_data, res_inst, alu_inst, alu_a, alu_b} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {alu_valid, res_valid, res_timeout, issue_cnt, res_data, res_inst, alu_inst, alu_a, alu_b});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_single_add;
    cmd_valid = 1'b1; cmd_inst = 4'd0; cmd_a = 16'h0400; cmd_b = 16'h0800;
    tick;  // t+1
    cmd_valid = 1'b0;
    checks++;
    if (alu_valid !== 1'b0) begin errors++; $display("FAIL add_t1_valid: got %b expected 0", alu_valid); end
    tick;  // t+2
    checks++;
    if (alu_valid !== 1'b1 || alu_inst !== 4'd0 || alu_a !== 16'h0400 || alu_b !== 16'h0800) begin
      errors++; $display("FAIL add_t2_issue: got v=%b i=%h a=%h b=%h expected v=1 i=0 a=0400 b=0800", alu_valid, alu_inst, alu_a, alu_b);
    end
    tick;  // t+3
    checks++;
    if (alu_valid !== 1'b0) begin errors++; $display("FAIL add_t3_valid: got %b expected 0", alu_valid); end
    tick;  // t+4
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL add_t4_res: got %b expected 0", res_valid); end
    tick;  // t+5
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0C00 || res_inst !== 4'd0 || res_timeout !== 1'b0 || issue_cnt !== 8'd1) begin
      errors++; $display("FAIL add_t5_result: got v=%b d=%h i=%h to=%b cnt=%0d expected v=1 d=0c00 i=0 to=0 cnt=1", res_valid, res_data, res_inst, res_timeout, issue_cnt);
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL add_release: got %b expected 0", res_valid); end
    exp_issue = exp_issue + 1;
  endtask

  task automatic test_fill_busy;
    int n;
    int extra;
    logic [ENT_W-1:0] e;
    exp_q.delete();
    force_busy = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      cmd_valid = 1'b1; cmd_inst = 4'(k); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      exp_q.push_back({cmd_inst, cmd_a, cmd_b});
      tick;
    end
    cmd_inst = 4'd4; cmd_a = 16'h1234; cmd_b = 16'h4321;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_low: got %b expected 0", cmd_ready); end
    repeat (3) tick;
    checks++;
    if (cmd_ready !== 1'b0 || alu_valid !== 1'b0) begin
      errors++; $display("FAIL fill_held: got ready=%b valid=%b expected 0 0", cmd_ready, alu_valid);
    end
    cmd_valid = 1'b0; force_busy = 1'b0; res_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < DEPTH; c++) begin
      tick;
      if (res_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {ENT_W{1'b1}};
        checks++;
        if (res_data !== alu_ref(e[35:32], e[31:16], e[15:0]) || res_inst !== e[35:32] || res_timeout !== 1'b0) begin
          errors++; $display("FAIL fill_result%0d: got d=%h i=%h to=%b expected d=%h i=%h to=0", n, res_data, res_inst, res_timeout, alu_ref(e[35:32], e[31:16], e[15:0]), e[35:32]);
        end
        n++;
      end
    end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL fill_count: got %0d expected %0d", n, DEPTH); end
    extra = 0;
    repeat (30) begin
      tick;
      if (res_valid === 1'b1 || alu_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL fill_fifth_rejected: got %0d extra cycles expected 0", extra); end
    res_ready = 1'b0;
    exp_issue = exp_issue + DEPTH;
  endtask

  task automatic test_hold_stall;
    bit found;
    logic [ENT_W-1:0] e;
    exp_q.delete();
    res_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cmd_valid = 1'b1; cmd_inst = 4'(5 + k); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      exp_q.push_back({cmd_inst, cmd_a, cmd_b});
      tick;
    end
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (res_valid === 1'b1) found = 1'b1; else tick;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hold_first_wait: got no result expected result within 50 cycles"); end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== alu_ref(e[35:32], e[31:16], e[15:0]) || res_inst !== 4'd5 || alu_valid !== 1'b0) begin
        errors++; $display("FAIL hold_stable%0d: got v=%b d=%h i=%h av=%b expected v=1 d=%h i=5 av=0", i, res_valid, res_data, res_inst, alu_valid, alu_ref(e[35:32], e[31:16], e[15:0]));
      end
      tick;
    end
    res_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      tick;
      if (res_valid === 1'b1) found = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!found || res_data !== alu_ref(e[35:32], e[31:16], e[15:0]) || res_inst !== 4'd6) begin
      errors++; $display("FAIL hold_second: got found=%b d=%h i=%h expected found=1 d=%h i=6", found, res_data, res_inst, alu_ref(e[35:32], e[31:16], e[15:0]));
    end
    tick;
    res_ready = 1'b0;
    exp_issue = exp_issue + 2;
  endtask

  task automatic test_timeout;
    bit found;
    bit seen;
    int n;
    exp_q.delete();
    alu_respond = 1'b0;
    cmd_valid = 1'b1; cmd_inst = 4'd9; cmd_a = 16'h7777; cmd_b = 16'h1111;
    tick;
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (alu_valid === 1'b1) found = 1'b1; else tick;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL timeout_issue: got no issue expected issue within 20 cycles"); end
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick;
      n++;
      if (res_valid === 1'b1) seen = 1'b1;
    end
`ifdef ALU_ISSUE_TIMEOUT_EN
    checks++;
    if (!seen || n != TMO + 1) begin errors++; $display("FAIL timeout_latency: got seen=%b n=%0d expected seen=1 n=%0d", seen, n, TMO + 1); end
    checks++;
    if (res_data !== 16'd0 || res_timeout !== 1'b1 || res_inst !== 4'd9) begin
      errors++; $display("FAIL timeout_result: got d=%h to=%b i=%h expected d=0000 to=1 i=9", res_data, res_timeout, res_inst);
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    exp_issue = exp_issue + 1;
`else
    checks++;
    if (seen) begin errors++; $display("FAIL no_timeout_wait: got result after %0d cycles expected none", n); end
    do_reset;
    exp_issue = 0;
`endif
    alu_respond = 1'b1;
  endtask

  task automatic test_reset_mid_wait;
    int stray;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_inst = 4'(k + 1); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      tick;
      if (k == 1) begin
        checks++;
        if (alu_valid !== 1'b1) begin errors++; $display("FAIL rstw_issue: got %b expected 1", alu_valid); end
      end
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({alu_valid, res_valid, res_timeout, issue_cnt, res_data, res_inst, alu_inst, alu_a, alu_b} !== 67'd0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstw_outputs: got %h ready=%b expected 0 ready=1", {alu_valid, res_valid, res_timeout, issue_cnt, res_data, res_inst, alu_inst, alu_a, alu_b}, cmd_ready);
    end
    inj_ov = 1'b1;
    tick;
    inj_ov = 1'b0;
    stray = 0;
    repeat (15) begin
      tick;
      if (res_valid === 1'b1 || alu_valid === 1'b1) stray++;
    end
    checks++;
    if (stray != 0 || issue_cnt !== 8'd0) begin
      errors++; $display("FAIL rstw_quiet: got activity=%0d cnt=%0d expected 0 0", stray, issue_cnt);
    end
    exp_issue = 0;
  endtask

  task automatic test_random;
    int acc, got, occ;
    bit prev_acc, prev_iss, prev_busy;
    logic [ENT_W-1:0] e;
    localparam int NCMD = 60;
    acc = 0; got = 0; occ = 0;
    prev_acc = 1'b0; prev_iss = 1'b0; prev_busy = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 4000 && got < NCMD; cyc++) begin
      if (prev_acc) occ++;
      if (prev_iss) occ--;
      checks++;
      if (cmd_ready !== (occ < DEPTH)) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, cmd_ready, occ < DEPTH); end
      if (alu_valid === 1'b1) begin
        checks++;
        if (prev_iss || prev_busy) begin errors++; $display("FAIL rand_issue_rule c%0d: got prev_valid=%b prev_busy=%b expected 0 0", cyc, prev_iss, prev_busy); end
        exp_issue++;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      if (res_valid === 1'b1 && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_result c%0d: got d=%h expected none", cyc, res_data);
        end else begin
          e = exp_q.pop_front();
          if (res_data !== alu_ref(e[35:32], e[31:16], e[15:0]) || res_inst !== e[35:32] || res_timeout !== 1'b0) begin
            errors++; $display("FAIL rand_result%0d: got d=%h i=%h to=%b expected d=%h i=%h to=0", got, res_data, res_inst, res_timeout, alu_ref(e[35:32], e[31:16], e[15:0]), e[35:32]);
          end
        end
        got++;
      end
      force_busy = ($urandom_range(0, 7) == 0);
      cmd_valid  = (acc < NCMD) && ($urandom_range(0, 2) != 0);
      cmd_inst = 4'($urandom_range(0, 15)); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      prev_acc = cmd_valid && (cmd_ready === 1'b1);
      if (prev_acc) begin
        acc++;
        exp_q.push_back({cmd_inst, cmd_a, cmd_b});
      end
      prev_iss  = (alu_valid === 1'b1);
      prev_busy = m_busy | force_busy;
      tick;
    end
    cmd_valid = 1'b0; force_busy = 1'b0; res_ready = 1'b0;
    checks++;
    if (got != NCMD || exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d results expected %0d", got, NCMD); end
    checks++;
    if (issue_cnt !== 8'(exp_issue)) begin errors++; $display("FAIL rand_issue_cnt: got %0d expected %0d", issue_cnt, exp_issue % 256); end
  endtask

  task automatic test_wrap;
    int acc, iss;
    bit prev_iss, done;
    do_reset;
    exp_issue = 0; acc = 0; iss = 0; prev_iss = 1'b0; done = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 4000 && !done; c++) begin
      if (prev_iss) begin
        iss++;
        if (iss == 255) begin
          checks++;
          if (issue_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", issue_cnt); end
        end
        if (iss == 256) begin
          checks++;
          if (issue_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", issue_cnt); end
          done = 1'b1;
        end
      end
      prev_iss  = (alu_valid === 1'b1);
      cmd_valid = (acc < 256);
      cmd_inst = 4'($urandom_range(0, 15)); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      if (cmd_valid && cmd_ready === 1'b1) acc++;
      tick;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL wrap_budget: got %0d issues expected 256", iss); end
    cmd_valid = 1'b0;
    repeat (10) tick;
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_add;
    test_fill_busy;
    test_hold_stall;
    test_timeout;
    test_reset_mid_wait;
    test_random;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
